elevator_scheduler: RTL and testbench
=====================================

Name: elevator_scheduler

Overview:
Car-motion scheduler for the elevator. It sits downstream of the debounced request outputs (queueUp, queueDown, queueinside) of the input-handling block. It latches hall and cabin calls into sticky pending masks and sequences the car using a LOOK policy: continue in the current direction while calls remain ahead, otherwise reverse. It drives the current floor, direction, motion and door status to the display and motor logic.

Parameters:
FLOOR, 6, number of floors; floors are numbered 0..FLOOR-1.
FW, 3, width of the floor index; must satisfy 2^FW >= FLOOR.
FLOOR_TICKS, 200, clock cycles to travel one floor (minimum 1).
DOOR_TICKS, 400, clock cycles the door stays open (minimum 1).

Ports:
clk  in  1  system clock (200 MHz).
rst_n  in  1  synchronous, active-low reset.
req_up  in  FLOOR  hall up calls; level, sampled every cycle; bit FLOOR-1 is ignored.
req_down  in  FLOOR  hall down calls; level, sampled every cycle; bit 0 is ignored.
req_inside  in  FLOOR  cabin floor buttons; level, sampled every cycle.
cur_floor  out  FW  current floor, binary.
dir  out  2  direction: 00 idle, 01 up, 10 down; 11 is never driven.
moving  out  1  high while in state MOVE.
door_open  out  1  high while in state DOOR.
arrive  out  1  one-cycle pulse on the cycle cur_floor changes.
pend_up  out  FLOOR  pending up-call mask.
pend_down  out  FLOOR  pending down-call mask.
pend_inside  out  FLOOR  pending cabin-call mask.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; all state is registered on posedge clk.
- Reset values: state IDLE; cur_floor 0; dir 00; moving 0; door_open 0; arrive 0; all pend masks 0; timer 0.
- Pending masks: pend_x[i] <= pend_x[i] | req_x[i] every cycle.
  - Masked bits (req_up[FLOOR-1], req_down[0]) never set.
  - If a set and a clear hit the same bit in the same cycle, the clear wins.
- Derived signals, combinational on registered masks:
  - any = OR of all three masks.
  - above = any pending bit at an index > cur_floor.
  - below = any pending bit at an index < cur_floor.
  - here = inside[f] | up[f] | down[f], where f = cur_floor.
- Stop-clear rule, applied on DOOR entry at floor f:
  - clear inside[f];
  - clear up[f] if dir==01, or dir==00, or !above;
  - clear down[f] if dir==10, or dir==00, or !below.
- State machine:
  - IDLE (dir 00):
    - if here -> DOOR;
    - else if above -> dir 01, MOVE;
    - else if below -> dir 10, MOVE;
    - else stay in IDLE.
    - Decision latency is one cycle; above has priority over below.
  - MOVE:
    - timer loads FLOOR_TICKS-1 on entry and decrements each cycle.
    - At timer 0: cur_floor moves by ±1 per dir, arrive pulses for that cycle, and the stop check is evaluated against the new floor on the next cycle.
    - Stop (-> DOOR) if inside[f], or the hall call at f in the travel direction, or no calls remain ahead while any call exists at f.
    - Otherwise, reload the timer and continue MOVE.
    - If nothing is ahead and nothing is at f -> IDLE with dir 00. This is defensive; it is unreachable in normal operation.
  - DOOR:
    - On entry: load timer DOOR_TICKS-1 and apply the stop-clear rule.
    - While open, a new call at f that the stop-clear rule would clear is cleared immediately and the timer reloads (door hold).
    - At timer 0, choose the next move:
      - calls ahead in dir -> MOVE, same dir;
      - else calls behind -> reverse dir, MOVE;
      - else a call remains at f (opposite hall call) -> reverse dir, re-enter DOOR and clear it;
      - else -> IDLE, dir 00.
- Boundaries:
  - cur_floor never exceeds FLOOR-1 and never goes below 0. At the top floor with dir up and no calls above, the car reverses or idles; it never increments.
  - The timer holds at 0 outside MOVE and DOOR.
- Reset mid-operation: rst_n low in any state returns every register to its reset value on the next clock edge. Pending calls are lost; the car reports floor 0.

Test Plan:
- Reset, then a one-cycle pulse req_inside[3] (FLOOR_TICKS=4, DOOR_TICKS=5) -> dir 01. Exactly three arrive pulses, 4 cycles apart. DOOR at floor 3 with door_open high for 5 cycles, pend_inside[3] cleared on DOOR entry, then IDLE with dir 00.
- At floor 0, req_up[2] and req_down[4] together -> stop at 2 (up call served), continue to 4. At floor 4, down[4] is cleared because nothing is above; then IDLE.
- Moving up from floor 1 toward inside[5]; req_down[3] arrives while passing -> no stop at 3. Stop at 5, reverse to dir 10, stop at 3 and clear down[3].
- Door open at floor 2 with dir up; req_up[2] is pressed every cycle for 3 cycles -> bit never latches, timer reloads each time, door closes DOOR_TICKS cycles after the last press.
- req_up[5] and req_down[0] asserted -> pend masks stay 0 and the car stays in IDLE.
- During MOVE between floors 2 and 3, pull rst_n low for 1 cycle -> next cycle: cur_floor 0, dir 00, moving 0, all masks 0.

Source files
------------

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: LOOK-policy car sequencer with sticky hall/cabin call masks
module elevator_scheduler #(
    parameter int FLOOR       = 6,
    parameter int FW          = 3,
    parameter int FLOOR_TICKS = 200,
    parameter int DOOR_TICKS  = 400
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [FLOOR-1:0] req_up,
    input  logic [FLOOR-1:0] req_down,
    input  logic [FLOOR-1:0] req_inside,
    output logic [FW-1:0]    cur_floor,
    output logic [1:0]       dir,
    output logic             moving,
    output logic             door_open,
    output logic             arrive,
    output logic [FLOOR-1:0] pend_up,
    output logic [FLOOR-1:0] pend_down,
    output logic [FLOOR-1:0] pend_inside
);

    localparam logic [1:0] D_IDLE = 2'b00;
    localparam logic [1:0] D_UP   = 2'b01;
    localparam logic [1:0] D_DN   = 2'b10;
    localparam int TMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0]    FT_LD = TW'(FLOOR_TICKS - 1);
    localparam logic [TW-1:0]    DT_LD = TW'(DOOR_TICKS - 1);
    localparam logic [FW-1:0]    TOP   = FW'(FLOOR - 1);
    localparam logic [FLOOR-1:0] UP_OK = {1'b0, {(FLOOR-1){1'b1}}};
    localparam logic [FLOOR-1:0] DN_OK = {{(FLOOR-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

    state_t           state, state_nxt;
    logic [1:0]       dir_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [FW-1:0]    floor_nxt;
    logic [FLOOR-1:0] any_mask, onehot, set_up, set_dn, clr_up, clr_dn, clr_in;
    logic             above, below, here, ahead, behind, at_dir, stop, hold, step;

    // Summarise the registered call masks relative to the car position
    always_comb begin
        any_mask = pend_up | pend_down | pend_inside;
        above    = 1'b0;
        below    = 1'b0;
        for (int i = 0; i < FLOOR; i++) begin
            above = above | (any_mask[i] & (FW'(i) > cur_floor));
            below = below | (any_mask[i] & (FW'(i) < cur_floor));
        end
        onehot = FLOOR'(1) << cur_floor;
        here   = any_mask[cur_floor];
        ahead  = (dir == D_DN) ? below : above;
        behind = (dir == D_DN) ? above : below;
        at_dir = (dir == D_UP) ? pend_up[cur_floor] : pend_down[cur_floor];
        stop   = pend_inside[cur_floor] | at_dir | (~ahead & here);
        set_up = req_up & UP_OK;
        set_dn = req_down & DN_OK;
        hold   = (state == S_DOOR) & (req_inside[cur_floor]
                 | (set_up[cur_floor] & ((dir != D_DN) | ~above))
                 | (set_dn[cur_floor] & ((dir != D_UP) | ~below)));
    end

    // Next state and travel direction under the LOOK policy
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        case (state)
            S_IDLE: begin
                if (here) begin
                    state_nxt = S_DOOR;
                end else if (above) begin
                    state_nxt = S_MOVE;
                    dir_nxt   = D_UP;
                end else if (below) begin
                    state_nxt = S_MOVE;
                    dir_nxt   = D_DN;
                end
            end
            S_MOVE: begin
                if (arrive && stop) begin
                    state_nxt = S_DOOR;
                end else if (arrive && !ahead) begin
                    state_nxt = S_IDLE;
                    dir_nxt   = D_IDLE;
                end
            end
            S_DOOR: begin
                if (!hold && timer == '0) begin
                    if (ahead) begin
                        state_nxt = S_MOVE;
                        dir_nxt   = (dir == D_IDLE) ? D_UP : dir;
                    end else if (behind) begin
                        state_nxt = S_MOVE;
                        dir_nxt   = (dir == D_DN) ? D_UP : D_DN;
                    end else if (here) begin
                        dir_nxt   = (dir == D_UP) ? D_DN : (dir == D_DN) ? D_UP : D_IDLE;
                    end else begin
                        state_nxt = S_IDLE;
                        dir_nxt   = D_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                dir_nxt   = D_IDLE;
            end
        endcase
    end

    // Status outputs, stop clears, floor stepping and timer reloads
    always_comb begin
        moving    = (state == S_MOVE);
        door_open = (state == S_DOOR);
        clr_in    = (state_nxt == S_DOOR) ? onehot : '0;
        clr_up    = ((state_nxt == S_DOOR) && ((dir_nxt != D_DN) || !above)) ? onehot : '0;
        clr_dn    = ((state_nxt == S_DOOR) && ((dir_nxt != D_UP) || !below)) ? onehot : '0;
        step      = (state == S_MOVE) && (state_nxt == S_MOVE) && (timer == '0)
                    && ((dir == D_UP) ? (cur_floor != TOP) : (dir == D_DN) ? (cur_floor != '0) : 1'b0);
        floor_nxt = !step ? cur_floor : (dir == D_UP) ? cur_floor + FW'(1) : cur_floor - FW'(1);
        timer_nxt = (state_nxt == S_MOVE) ? (((state != S_MOVE) || (timer == '0)) ? FT_LD : timer - TW'(1))
                  : (state_nxt == S_DOOR) ? (((state != S_DOOR) || hold || (timer == '0)) ? DT_LD : timer - TW'(1))
                  : '0;
    end

    // State register
    always_ff @(posedge clk) begin
        state <= !rst_n ? S_IDLE : state_nxt;
    end

    // Car position, direction, timer and pending masks; a clear beats a same-cycle set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_floor   <= '0;
            dir         <= D_IDLE;
            arrive      <= 1'b0;
            timer       <= '0;
            pend_up     <= '0;
            pend_down   <= '0;
            pend_inside <= '0;
        end else begin
            cur_floor   <= floor_nxt;
            dir         <= dir_nxt;
            arrive      <= step;
            timer       <= timer_nxt;
            pend_up     <= (pend_up | set_up) & ~clr_up;
            pend_down   <= (pend_down | set_dn) & ~clr_dn;
            pend_inside <= (pend_inside | req_inside) & ~clr_in;
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: vector table, scenario sequences and randomized model comparison
module tb_elevator_scheduler;

    localparam int NF = 6;
    localparam int FT = 4;
    localparam int DT = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NF-1:0] req_up = '0, req_down = '0, req_inside = '0;
    logic [2:0]    cur_floor;
    logic [1:0]    dir;
    logic          moving, door_open, arrive;
    logic [NF-1:0] pend_up, pend_down, pend_inside;
    logic [31:0]   dut_vec;

    int errors = 0;
    int checks = 0;

    elevator_scheduler #(.FLOOR(NF), .FW(3), .FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_up(req_up), .req_down(req_down), .req_inside(req_inside),
        .cur_floor(cur_floor), .dir(dir), .moving(moving), .door_open(door_open),
        .arrive(arrive), .pend_up(pend_up), .pend_down(pend_down), .pend_inside(pend_inside)
    );

    always #5 clk = ~clk;

    assign dut_vec = {6'b0, cur_floor, dir, moving, door_open, arrive, pend_up, pend_down, pend_inside};

    typedef struct {
        logic [NF-1:0] up, dn, in;
        logic [NF-1:0] e_up, e_dn, e_in;
        logic [1:0]    e_dir;
        logic          e_mov, e_door;
        logic [NF-1:0] e_up2, e_dn2, e_in2;
    } vec_t;
    vec_t tv[6];

    int            door_floors[$];
    logic [NF-1:0] door_pu[$], door_pd[$], door_pi[$];
    logic [1:0]    door_dir[$];

    // reference model: integer floor, signed direction, phase countdown
    int            m_st, m_dir, m_floor, m_tmr;
    bit            m_arr;
    bit [NF-1:0]   m_pu, m_pd, m_pi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_up = '0;
        req_down = '0;
        req_inside = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_idle(input int max_cyc, input string name);
        bit prev_door = 1'b0;
        bit done = 1'b0;
        door_floors.delete();
        door_pu.delete();
        door_pd.delete();
        door_pi.delete();
        door_dir.delete();
        for (int c = 0; c < max_cyc && !done; c++) begin
            if (door_open && !prev_door) begin
                door_floors.push_back(int'(cur_floor));
                door_pu.push_back(pend_up);
                door_pd.push_back(pend_down);
                door_pi.push_back(pend_inside);
                door_dir.push_back(dir);
            end
            prev_door = door_open;
            if (c > 0 && !moving && !door_open && (pend_up | pend_down | pend_inside) == '0) done = 1'b1;
            else @(negedge clk);
        end
        chk({name, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic m_reset();
        m_st = 0;
        m_dir = 0;
        m_floor = 0;
        m_tmr = 0;
        m_arr = 1'b0;
        m_pu = '0;
        m_pd = '0;
        m_pi = '0;
    endtask

    function automatic bit m_call(input int i);
        return m_pu[i] | m_pd[i] | m_pi[i];
    endfunction

    function automatic logic [31:0] m_pack();
        logic [2:0] fl;
        fl = m_floor[2:0];
        return {6'b0, fl, (m_dir == 1) ? 2'b01 : (m_dir == -1) ? 2'b10 : 2'b00,
                m_st == 1, m_st == 2, m_arr, m_pu, m_pd, m_pi};
    endfunction

    // advance the model by one clock using the inputs about to be sampled
    task automatic model_step();
        int f, nst, ndir;
        bit ab, be, hr, ahead, behind, hold, step;
        if (!rst_n) begin
            m_reset();
            return;
        end
        f = m_floor;
        ab = 1'b0;
        be = 1'b0;
        for (int i = 0; i < NF; i++) begin
            if (i > f && m_call(i)) ab = 1'b1;
            if (i < f && m_call(i)) be = 1'b1;
        end
        hr = m_call(f);
        ahead = (m_dir < 0) ? be : ab;
        behind = (m_dir < 0) ? ab : be;
        hold = (m_st == 2) && (req_inside[f] || (req_up[f] && f != NF-1 && (m_dir != -1 || !ab))
               || (req_down[f] && f != 0 && (m_dir != 1 || !be)));
        nst = m_st;
        ndir = m_dir;
        step = 1'b0;
        if (m_st == 0) begin
            if (hr) begin nst = 2; m_tmr = DT-1; end
            else if (ab) begin nst = 1; ndir = 1; m_tmr = FT-1; end
            else if (be) begin nst = 1; ndir = -1; m_tmr = FT-1; end
            else m_tmr = 0;
        end else if (m_st == 1) begin
            if (m_arr && (m_pi[f] || (m_dir == 1 ? m_pu[f] : m_pd[f]) || (!ahead && hr))) begin
                nst = 2; m_tmr = DT-1;
            end else if (m_arr && !ahead) begin
                nst = 0; ndir = 0; m_tmr = 0;
            end else if (m_tmr == 0) begin
                step = (f + m_dir >= 0) && (f + m_dir < NF);
                m_tmr = FT-1;
            end else m_tmr--;
        end else begin
            if (hold) m_tmr = DT-1;
            else if (m_tmr > 0) m_tmr--;
            else if (ahead) begin nst = 1; ndir = (m_dir == 0) ? 1 : m_dir; m_tmr = FT-1; end
            else if (behind) begin nst = 1; ndir = (m_dir == -1) ? 1 : -1; m_tmr = FT-1; end
            else if (hr) begin ndir = -m_dir; m_tmr = DT-1; end
            else begin nst = 0; ndir = 0; m_tmr = 0; end
        end
        for (int i = 0; i < NF; i++) begin
            if (req_up[i] && i != NF-1) m_pu[i] = 1'b1;
            if (req_down[i] && i != 0) m_pd[i] = 1'b1;
            if (req_inside[i]) m_pi[i] = 1'b1;
        end
        if (nst == 2) begin
            m_pi[f] = 1'b0;
            if (ndir != -1 || !ab) m_pu[f] = 1'b0;
            if (ndir != 1 || !be) m_pd[f] = 1'b0;
        end
        if (step) m_floor = m_floor + m_dir;
        m_arr = step;
        m_st = nst;
        m_dir = ndir;
    endtask

    initial begin
        int arr_c[$];
        int dcount;

        tv[0] = '{6'b000000, 6'b000000, 6'b001000, 6'b000000, 6'b000000, 6'b001000, 2'b01, 1'b1, 1'b0, 6'b000000, 6'b000000, 6'b001000};
        tv[1] = '{6'b100000, 6'b000001, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 2'b00, 1'b0, 1'b0, 6'b000000, 6'b000000, 6'b000000};
        tv[2] = '{6'b000000, 6'b000000, 6'b000001, 6'b000000, 6'b000000, 6'b000001, 2'b00, 1'b0, 1'b1, 6'b000000, 6'b000000, 6'b000000};
        tv[3] = '{6'b000001, 6'b000000, 6'b000000, 6'b000001, 6'b000000, 6'b000000, 2'b00, 1'b0, 1'b1, 6'b000000, 6'b000000, 6'b000000};
        tv[4] = '{6'b001000, 6'b000100, 6'b000000, 6'b001000, 6'b000100, 6'b000000, 2'b01, 1'b1, 1'b0, 6'b001000, 6'b000100, 6'b000000};
        tv[5] = '{6'b111111, 6'b111111, 6'b111111, 6'b011111, 6'b111110, 6'b111111, 2'b00, 1'b0, 1'b1, 6'b011110, 6'b111110, 6'b111110};

        do_reset();
        chk("reset_state", dut_vec, 32'd0);

        for (int k = 0; k < 6; k++) begin
            do_reset();
            req_up = tv[k].up;
            req_down = tv[k].dn;
            req_inside = tv[k].in;
            @(negedge clk);
            req_up = '0;
            req_down = '0;
            req_inside = '0;
            chk($sformatf("tv%0d_pend", k), 32'({pend_up, pend_down, pend_inside}), 32'({tv[k].e_up, tv[k].e_dn, tv[k].e_in}));
            @(negedge clk);
            chk($sformatf("tv%0d_ctrl", k), 32'({dir, moving, door_open}), 32'({tv[k].e_dir, tv[k].e_mov, tv[k].e_door}));
            chk($sformatf("tv%0d_pend2", k), 32'({pend_up, pend_down, pend_inside}), 32'({tv[k].e_up2, tv[k].e_dn2, tv[k].e_in2}));
        end

        // single cabin call to floor 3
        do_reset();
        req_inside = 6'b001000;
        @(negedge clk);
        req_inside = '0;
        dcount = 0;
        for (int c = 0; c < 100; c++) begin
            if (arrive) arr_c.push_back(c);
            if (door_open) begin
                if (dcount == 0) chk("s1_door_entry", 32'({cur_floor, pend_inside}), 32'({3'd3, 6'b000000}));
                dcount++;
            end
            if (c == 1) chk("s1_dir_up", 32'({dir, moving}), 32'({2'b01, 1'b1}));
            @(negedge clk);
        end
        chk("s1_arrive_count", arr_c.size(), 3);
        if (arr_c.size() == 3) begin
            chk("s1_first_arrive", arr_c[0], 5);
            chk("s1_gap1", arr_c[1] - arr_c[0], FT);
            chk("s1_gap2", arr_c[2] - arr_c[1], FT);
        end
        chk("s1_door_cycles", dcount, DT);
        chk("s1_final_idle", 32'({dir, moving, door_open, cur_floor}), 32'({2'b00, 1'b0, 1'b0, 3'd3}));

        // up call at 2 and down call at 4 from floor 0
        do_reset();
        req_up = 6'b000100;
        req_down = 6'b010000;
        @(negedge clk);
        req_up = '0;
        req_down = '0;
        run_idle(200, "s2");
        chk("s2_stops", door_floors.size(), 2);
        if (door_floors.size() == 2) begin
            chk("s2_first_stop", door_floors[0], 2);
            chk("s2_second_stop", door_floors[1], 4);
            chk("s2_up2_cleared", 32'({door_pu[0][2], door_pd[0][4]}), 32'({1'b0, 1'b1}));
            chk("s2_down4_cleared", 32'(door_pd[1][4]), 32'd0);
        end
        chk("s2_final_dir", 32'(dir), 32'd0);

        // down call at 3 while passing upward toward 5
        do_reset();
        req_inside = 6'b000010;
        @(negedge clk);
        req_inside = '0;
        run_idle(100, "s3a");
        chk("s3_at_floor1", 32'(cur_floor), 32'd1);
        req_inside = 6'b100000;
        @(negedge clk);
        req_inside = '0;
        for (int c = 0; c < 100 && !(cur_floor == 3'd2 && moving); c++) @(negedge clk);
        chk("s3_reach2", 32'({cur_floor, moving}), 32'({3'd2, 1'b1}));
        req_down = 6'b001000;
        @(negedge clk);
        req_down = '0;
        run_idle(300, "s3b");
        chk("s3_stops", door_floors.size(), 2);
        if (door_floors.size() == 2) begin
            chk("s3_first_stop", door_floors[0], 5);
            chk("s3_second_stop", door_floors[1], 3);
            chk("s3_dir_down", 32'(door_dir[1]), 32'(2'b10));
            chk("s3_down3_cleared", 32'({door_pd[0][3], door_pd[1][3]}), 32'({1'b1, 1'b0}));
        end

        // door hold at floor 2 heading up
        do_reset();
        req_inside = 6'b010100;
        @(negedge clk);
        req_inside = '0;
        for (int c = 0; c < 100 && !door_open; c++) @(negedge clk);
        chk("s4_door_at2", 32'({door_open, cur_floor, dir}), 32'({1'b1, 3'd2, 2'b01}));
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            req_up = 6'b000100;
            @(negedge clk);
            chk($sformatf("s4_hold%0d", k), 32'({door_open, pend_up[2]}), 32'({1'b1, 1'b0}));
        end
        req_up = '0;
        dcount = 0;
        for (int c = 0; c < 50 && door_open; c++) begin
            dcount++;
            @(negedge clk);
        end
        chk("s4_close_after", dcount, DT);

        // masked hall bits never latch
        do_reset();
        req_up = 6'b100000;
        req_down = 6'b000001;
        repeat (10) @(negedge clk);
        req_up = '0;
        req_down = '0;
        chk("s5_masked", dut_vec, 32'd0);

        // reset while travelling between floors 2 and 3
        do_reset();
        req_inside = 6'b100000;
        @(negedge clk);
        req_inside = '0;
        for (int c = 0; c < 100 && !(cur_floor == 3'd2 && moving); c++) @(negedge clk);
        chk("s6_reach2", 32'({cur_floor, moving}), 32'({3'd2, 1'b1}));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("s6_midreset", dut_vec, 32'd0);

        // randomized traffic against the reference model
        do_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            chk($sformatf("model_c%0d", c), dut_vec, m_pack());
            req_up = '0;
            req_down = '0;
            req_inside = '0;
            if ($urandom_range(0, 24) == 0) req_up[$urandom_range(0, NF-1)] = 1'b1;
            if ($urandom_range(0, 24) == 0) req_down[$urandom_range(0, NF-1)] = 1'b1;
            if ($urandom_range(0, 19) == 0) req_inside[$urandom_range(0, NF-1)] = 1'b1;
            if (m_st == 2 && $urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) req_up[m_floor] = 1'b1;
                else req_down[m_floor] = 1'b1;
            end
            rst_n = ($urandom_range(0, 999) != 0);
            model_step();
            @(negedge clk);
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
